// File: rtl/jogo_pkg.sv
// jogo_pkg: shared move width, FSM encoding and player indices for the move-capture stage
package jogo_pkg;
  localparam int MOVE_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, COLETA, COMPARA, APRESENTA} estado_t;
  localparam int J1 = 0;
  localparam int J2 = 1;
  localparam int J3 = 2;
  localparam int J4 = 3;
endpackage

// File: rtl/comparador_pares.sv
// comparador_pares: six pairwise equality bits of four moves, ordered {12,13,14,23,24,34}
module comparador_pares
  import jogo_pkg::*;
#(
  parameter int W = MOVE_W_DEF
) (
  input  logic [4*W-1:0] jogada,
  output logic [5:0]     iguais
);
  logic [W-1:0] a, b, c, d;
  assign a = jogada[J1*W +: W];
  assign b = jogada[J2*W +: W];
  assign c = jogada[J3*W +: W];
  assign d = jogada[J4*W +: W];
  assign iguais = {a == b, a == c, a == d, b == c, b == d, c == d};
endmodule

// File: rtl/captura_jogadas.sv
// captura_jogadas: locks one move per player per round, registers pairwise-equality flags
// and holds them with Comp_Valid until Ack; a stalled round aborts with a Timeout pulse.
module captura_jogadas
  import jogo_pkg::*;
#(
  parameter int MOVE_W  = MOVE_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [4*MOVE_W-1:0] Jogada,
  input  logic [3:0]          Valid,
  input  logic                Ack,
  output logic                Pronto,
  output logic [3:0]          Travado,
  output logic                XJ1eJ2,
  output logic                XJ1eJ3,
  output logic                XJ1eJ4,
  output logic                XJ2eJ3,
  output logic                XJ2eJ4,
  output logic                XJ3eJ4,
  output logic                Comp_Valid,
  output logic                Timeout
);
  localparam logic [15:0] LIMITE = 16'(TIMEOUT - 1);
  estado_t             state;
  logic [15:0]         cnt;
  logic [4*MOVE_W-1:0] moves, moves_next;
  logic [5:0]          flags, iguais;
  logic [3:0]          novo, mask_next;
  assign novo      = Valid & ~Travado;
  assign mask_next = Travado | Valid;
  assign Pronto    = (state == IDLE) || (state == COLETA);
  assign {XJ1eJ2, XJ1eJ3, XJ1eJ4, XJ2eJ3, XJ2eJ4, XJ3eJ4} = flags;
  // first offer per player wins; already-locked slices keep their move
  always_comb begin
    moves_next = moves;
    for (int i = 0; i < 4; i++)
      if (novo[i]) moves_next[i*MOVE_W +: MOVE_W] = Jogada[i*MOVE_W +: MOVE_W];
  end
  comparador_pares #(.W(MOVE_W)) u_cmp (.jogada(moves), .iguais(iguais));
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      moves      <= '0;
      flags      <= '0;
      Travado    <= '0;
      Comp_Valid <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE: if (|Valid) begin
          Travado <= mask_next;
          moves   <= moves_next;
          cnt     <= '0;
          state   <= &mask_next ? COMPARA : COLETA;
        end
        COLETA: if (&mask_next) begin
          Travado <= mask_next;
          moves   <= moves_next;
          state   <= COMPARA;
        end else if (cnt == LIMITE) begin
          Travado <= '0;
          moves   <= '0;
          Timeout <= 1'b1;
          state   <= IDLE;
        end else begin
          Travado <= mask_next;
          moves   <= moves_next;
          cnt     <= cnt + 16'd1;
        end
        COMPARA: begin
          flags <= iguais;
          state <= APRESENTA;
        end
        APRESENTA: if (Comp_Valid && Ack) begin
          Comp_Valid <= 1'b0;
          flags      <= '0;
          Travado    <= '0;
          moves      <= '0;
          state      <= IDLE;
        end else Comp_Valid <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_captura_jogadas.sv
// tb_captura_jogadas: directed scenarios plus randomized traffic against a round-level model
module tb_captura_jogadas;
  localparam int W = 2;
  localparam int T = 8;
  logic         Clk = 0, Reset = 0, Ack = 0;
  logic [4*W-1:0] Jogada = '0;
  logic [3:0]   Valid = '0;
  logic         Pronto, Comp_Valid, Timeout;
  logic [3:0]   Travado;
  logic         XJ1eJ2, XJ1eJ3, XJ1eJ4, XJ2eJ3, XJ2eJ4, XJ3eJ4;
  logic [5:0]   x;
  int           n_tests = 0, n_fail = 0;
  bit           lk[4];
  int           mv[4];
  int           age = 0, done = -1;
  bit           to_exp = 0;
  assign x = {XJ1eJ2, XJ1eJ3, XJ1eJ4, XJ2eJ3, XJ2eJ4, XJ3eJ4};

  captura_jogadas #(.MOVE_W(W), .TIMEOUT(T)) dut (
    .Clk(Clk), .Reset(Reset), .Jogada(Jogada), .Valid(Valid), .Ack(Ack),
    .Pronto(Pronto), .Travado(Travado),
    .XJ1eJ2(XJ1eJ2), .XJ1eJ3(XJ1eJ3), .XJ1eJ4(XJ1eJ4),
    .XJ2eJ3(XJ2eJ3), .XJ2eJ4(XJ2eJ4), .XJ3eJ4(XJ3eJ4),
    .Comp_Valid(Comp_Valid), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  function automatic logic [4*W-1:0] jog(int a, int b, int c, int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin lk[i] = 0; mv[i] = 0; end
    age = 0; done = -1; to_exp = 0;
  endtask

  // round-level view: a round is accepting until all four are locked, then
  // flags appear one edge later and are announced valid one edge after that
  task automatic model_step();
    bit pre, any, all;
    to_exp = 0;
    if (done < 0) begin
      pre = lk[0] | lk[1] | lk[2] | lk[3];
      for (int i = 0; i < 4; i++)
        if (Valid[i] && !lk[i]) begin lk[i] = 1; mv[i] = int'(Jogada[i*W +: W]); end
      any = lk[0] | lk[1] | lk[2] | lk[3];
      all = lk[0] & lk[1] & lk[2] & lk[3];
      if (all) done = 0;
      else if (pre) begin
        if (age == T - 1) begin model_reset(); to_exp = 1; end
        else age++;
      end else if (any) age = 0;
    end else if (done >= 2 && Ack) model_reset();
    else if (done < 2) done++;
  endtask

  task automatic check_all();
    logic [5:0] ef;
    logic [3:0] em;
    ef = '0;
    if (done >= 1)
      ef = {6{1'b1}} & {mv[0] == mv[1], mv[0] == mv[2], mv[0] == mv[3],
                        mv[1] == mv[2], mv[1] == mv[3], mv[2] == mv[3]};
    em = {lk[3], lk[2], lk[1], lk[0]};
    check("travado", 32'(Travado), 32'(em));
    check("flags", 32'(x), 32'(ef));
    check("pronto", 32'(Pronto), 32'(done < 0));
    check("comp_valid", 32'(Comp_Valid), 32'(done >= 2));
    check("timeout", 32'(Timeout), 32'(to_exp));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(logic [3:0] v, logic [4*W-1:0] j, logic a);
    Valid = v; Jogada = j; Ack = a;
    tick();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_travado"}, 32'(Travado), 0);
    check({tag, "_flags"}, 32'(x), 0);
    check({tag, "_cv"}, 32'(Comp_Valid), 0);
    check({tag, "_to"}, 32'(Timeout), 0);
    check({tag, "_pronto"}, 32'(Pronto), 1);
  endtask

  task automatic async_reset(string tag);
    #3 Reset = 1;
    #1 check_reset_vals(tag);
    model_reset();
    @(posedge Clk);
    #2 Reset = 0;
    Valid = '0; Ack = 0;
  endtask

  initial begin
    int n;
    model_reset();
    Reset = 1;
    #2 check_reset_vals("rst");
    @(posedge Clk);
    #2 Reset = 0;

    // 1: separate locks, all distinct
    drive(4'b0001, jog(1, 0, 0, 0), 0);
    drive(4'b0010, jog(0, 2, 0, 0), 0);
    drive(4'b0100, jog(0, 0, 3, 0), 0);
    drive(4'b1000, jog(0, 0, 0, 0), 0);
    drive(4'b0000, '0, 0);
    check("t1_cv_k1", 32'(Comp_Valid), 0);
    drive(4'b0000, '0, 0);
    check("t1_cv_k2", 32'(Comp_Valid), 1);
    check("t1_flags", 32'(x), 0);
    drive(4'b0000, '0, 1);
    check("t1_cleared", 32'(Comp_Valid), 0);
    Ack = 0;

    // 2: all four in one cycle
    drive(4'b1111, jog(2, 2, 1, 2), 0);
    drive(4'b0000, '0, 0);
    drive(4'b0000, '0, 0);
    check("t2_cv", 32'(Comp_Valid), 1);
    check("t2_flags", 32'(x), 32'(6'b101010));
    drive(4'b0000, '0, 1);

    // 3: first move wins
    drive(4'b0001, jog(3, 0, 0, 0), 0);
    drive(4'b0001, jog(0, 0, 0, 0), 0);
    drive(4'b1110, jog(0, 2, 1, 3), 0);
    drive(4'b0000, '0, 0);
    drive(4'b0000, '0, 0);
    check("t3_flags", 32'(x), 32'(6'b001000));
    drive(4'b0000, '0, 1);

    // 4: stalled round
    drive(4'b0001, jog(1, 0, 0, 0), 0);
    n = 0;
    drive(4'b0100, jog(0, 0, 2, 0), 0);
    n++;
    while (!Timeout && n < 20) begin drive(4'b0000, '0, 0); n++; end
    check("t4_timeout_at", 32'(n), 32'(T));
    check("t4_travado", 32'(Travado), 0);
    check("t4_pronto", 32'(Pronto), 1);
    drive(4'b0000, '0, 0);
    check("t4_pulse_end", 32'(Timeout), 0);

    // 5: hold in presentation
    drive(4'b1111, jog(0, 1, 0, 1), 0);
    drive(4'b0000, '0, 0);
    drive(4'b0000, '0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(4'($urandom), 8'($urandom), 0);
      check("t5_cv", 32'(Comp_Valid), 1);
      check("t5_pronto", 32'(Pronto), 0);
      check("t5_flags", 32'(x), 32'(6'b010010));
    end
    drive(4'b0000, '0, 1);

    // 6: asynchronous reset in collection and in presentation
    drive(4'b0001, jog(1, 0, 0, 0), 0);
    drive(4'b0110, jog(0, 2, 3, 0), 0);
    check("t6_mask", 32'(Travado), 32'(4'b0111));
    async_reset("t6a");
    drive(4'b1111, jog(1, 1, 1, 1), 0);
    drive(4'b0000, '0, 0);
    drive(4'b0000, '0, 0);
    check("t6_cv", 32'(Comp_Valid), 1);
    async_reset("t6b");

    // random traffic
    for (int i = 0; i < 500; i++)
      drive(4'($urandom) & 4'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
